seg_scan_reader: RTL and testbench
==================================

# seg_scan_reader

Receive-side counterpart of the seven-segment digit decoder: it watches a multiplexed, active-low seven-segment bus (anode strobes plus gfedcba segments) and reconstructs the digit values being displayed. Each digit is filtered for stability before it is committed. Used in lab self-check harnesses and loopback tests where a display driver's pin outputs must be checked against the intended values.

## Interface
- NDIGITS, 8: number of anodes scanned (≥1)
- STABLE_CNT, 3: consecutive identical samples required before commit (≥1)

- clk  in  1  system clock, rising-edge
- rst  in  1  reset, asynchronous, active-high
- an_n  in  NDIGITS  anode strobes, active-low, one-hot-low when a digit is lit
- segs_n  in  7  segments, active-low, bit 6 = g … bit 0 = a
- digits  out  4*NDIGITS  decoded values, digit i at [4i+3:4i]
- digit_valid  out  NDIGITS  1 = last commit for digit i was a legal pattern
- frame_done  out  1  one-cycle pulse: every digit committed since last pulse
- err  out  1  one-cycle pulse: illegal segment pattern committed
- err_idx  out  $clog2(NDIGITS) (min 1)  digit index of the last err; valid with err

## Operation
- Input stage: an_n and segs_n are registered every cycle. Reset value: all ones (blank).
- Anode check: a sample is "lit" only if exactly one an_n bit is 0. idx = position of that bit. All-ones or multiple-low samples are "blank".
- Inverse decode table (segs_n → value): 1000000→0, 1111001→1, 0100100→2, 0110000→3, 0011001→4, 0010010→5, 0000010→6, 1111000→7, 0000000→8, 0010000→9. Any other pattern is illegal.
- FSM, one per block, driven by the registered sample. The sample is compared with the previous registered sample (anode and segs).
  - IDLE: current sample blank. On a lit sample → TRACK with run=1.
  - TRACK: lit and equal to previous → run+1. Lit and different → run=1, stay. Blank → IDLE. When run reaches STABLE_CNT, commit and → HELD.
  - HELD: lit and equal → stay, no recommit. Lit and different → TRACK, run=1. Blank → IDLE.
  - STABLE_CNT=1: a lit sample commits on the cycle it is seen. The FSM goes IDLE/TRACK → HELD directly.
- Commit for digit idx:
  - Legal pattern: digits[idx] = value, digit_valid[idx] = 1.
  - Illegal pattern: digits[idx] unchanged, digit_valid[idx] = 0, err = 1, err_idx = idx.
  - Set commit-mask bit idx.
- Frame: when the commit mask reaches all ones, pulse frame_done for one cycle and clear the mask in the same cycle. A commit that lands in that same cycle is kept in the new mask.
- Run counter width is $clog2(STABLE_CNT+1). It saturates at STABLE_CNT and never wraps.
- Reset values:
  - digits = 0, digit_valid = 0, frame_done = 0, err = 0, err_idx = 0.
  - State IDLE, run = 0, mask = 0.

## Timing
- Pattern on the pins before edge 1 and held: sampled at edges 1…STABLE_CNT. The commit is visible in outputs after edge STABLE_CNT+1. Latency = STABLE_CNT+1 cycles.
- err and frame_done are registered. They assert in the same cycle the digits/digit_valid update and deassert on the next edge.
- frame_done asserts in the same cycle as the commit that completes the mask.
- Reset asserted mid-run clears all state and outputs immediately, with no clock needed. After release, the first commit again needs the full STABLE_CNT+1 cycles.
- Glitches shorter than STABLE_CNT samples never commit. They restart the run.

## Configuration
- SEG_READER_DASH_EN defined: pattern 0111111 (dash) is legal. It commits value 4'hF with digit_valid = 1 and raises no err.
- Undefined: 0111111 is illegal and follows the illegal-pattern commit rule.

## Test plan
- Reset, then hold an_n=11111110, segs_n=0100100 with STABLE_CNT=3 → after 4 edges digits[3:0]=2, digit_valid[0]=1, err=0, frame_done=0.
- Scan digits 0…7 with values 0…7, each held 5 cycles → frame_done pulses once, in the cycle digit 7 commits. digits=32'h76543210, digit_valid=8'hFF.
- Digit 3 held 2 cycles with 0000000, then changed to 1111001 for 3 cycles → no commit of 8. Digit 3 reads 1 after the 4th edge of the new pattern.
- Digit 5 held with 0111111 → without SEG_READER_DASH_EN: err pulse, err_idx=5, digit_valid[5]=0, digits[23:20] unchanged. With SEG_READER_DASH_EN: digits[23:20]=F, digit_valid[5]=1, no err.
- an_n=11110011 (two low) held 10 cycles → no commit, outputs unchanged.
- Assert rst asynchronously while digit 1 is at run=2 → all outputs 0 before the next edge. After release, the same pattern needs 4 edges to commit.

Source files
------------

// File: rtl/seg_scan_reader_if.sv
// -----------------------------------------------------------------------------
// seg_scan_reader_if
// Bundles the multiplexed seven-segment bus being observed together with the
// reconstructed digit outputs of seg_scan_reader.
//   master : drives an_n / segs_n (display side), reads decoded results
//   slave  : seg_scan_reader itself
// Signals:
//   an_n        [NDIGITS-1:0]   anode strobes, active-low
//   segs_n      [6:0]           segments gfedcba, active-low
//   digits      [4*NDIGITS-1:0] decoded values, digit i at [4i+3:4i]
//   digit_valid [NDIGITS-1:0]   last commit of digit i was a legal pattern
//   frame_done                  one-cycle pulse, every digit committed
//   err                         one-cycle pulse, illegal pattern committed
//   err_idx     [IDXW-1:0]      digit index of the last err
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
interface seg_scan_reader_if #(
   parameter int NDIGITS = 8
);
   localparam int IDXW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

   logic [NDIGITS-1:0]   an_n;
   logic [6:0]           segs_n;
   logic [4*NDIGITS-1:0] digits;
   logic [NDIGITS-1:0]   digit_valid;
   logic                 frame_done;
   logic                 err;
   logic [IDXW-1:0]      err_idx;

   modport master (
      output an_n, segs_n,
      input  digits, digit_valid, frame_done, err, err_idx
   );

   modport slave (
      input  an_n, segs_n,
      output digits, digit_valid, frame_done, err, err_idx
   );
endinterface

// File: rtl/seg_scan_reader.sv
// -----------------------------------------------------------------------------
// seg_scan_reader
// Watches a multiplexed active-low seven-segment bus and reconstructs the
// digit values being displayed. A digit is committed only after STABLE_CNT
// consecutive identical lit samples; illegal patterns raise err.
// Ports:
//   clk    system clock, rising edge
//   rst    asynchronous active-high reset
//   io_bus seg_scan_reader_if.slave (an_n/segs_n in; digits, digit_valid,
//          frame_done, err, err_idx out)
// Parameters:
//   NDIGITS    number of anodes scanned (>=1)
//   STABLE_CNT identical samples required before a commit (>=1)
// Build option:
//   SEG_READER_DASH_EN  when defined, the dash pattern 0111111 decodes as a
//                       legal value 4'hF instead of an illegal pattern.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module seg_scan_reader #(
   parameter int NDIGITS    = 8,
   parameter int STABLE_CNT = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   seg_scan_reader_if.slave      io_bus
);
   localparam int IDXW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
   localparam int RUNW = $clog2(STABLE_CNT + 1);
   localparam logic [RUNW-1:0]    RUN_MAX   = RUNW'(STABLE_CNT);
   localparam logic [RUNW-1:0]    RUN_ONE   = RUNW'(1);
   localparam logic [NDIGITS-1:0] MASK_FULL = '1;

   typedef enum logic [1:0] {S_IDLE, S_TRACK, S_HELD} state_t;

   // Inverse segment table: returns {legal, value}.
   function automatic logic [4:0] seg_decode(input logic [6:0] s);
      case (s)
         7'b1000000: return {1'b1, 4'd0};
         7'b1111001: return {1'b1, 4'd1};
         7'b0100100: return {1'b1, 4'd2};
         7'b0110000: return {1'b1, 4'd3};
         7'b0011001: return {1'b1, 4'd4};
         7'b0010010: return {1'b1, 4'd5};
         7'b0000010: return {1'b1, 4'd6};
         7'b1111000: return {1'b1, 4'd7};
         7'b0000000: return {1'b1, 4'd8};
         7'b0010000: return {1'b1, 4'd9};
`ifdef SEG_READER_DASH_EN
         7'b0111111: return {1'b1, 4'hF};
`endif
         default:    return {1'b0, 4'd0};
      endcase
   endfunction

   // _p0 is the current registered sample, _p1 the one before it.
   logic [NDIGITS-1:0]   r_an_p0, r_an_p1;
   logic [6:0]           r_segs_p0, r_segs_p1;
   state_t               r_state;
   logic [RUNW-1:0]      r_run;
   logic [NDIGITS-1:0]   r_mask;
   logic [4*NDIGITS-1:0] r_digits;
   logic [NDIGITS-1:0]   r_valid;
   logic                 r_frame;
   logic                 r_err;
   logic [IDXW-1:0]      r_err_idx;

   logic                 w_lit;
   logic                 w_same;
   logic [IDXW-1:0]      w_idx;
   logic [4:0]           w_dec;
   state_t               w_state_nxt;
   logic [RUNW-1:0]      w_run_nxt;
   logic                 w_commit;
   logic [NDIGITS-1:0]   w_commit_bit;
   logic [NDIGITS-1:0]   w_mask_nxt;

   // Sample classification: lit only when exactly one anode is low.
   always_comb begin
      w_lit  = $onehot(~r_an_p0);
      w_same = (r_an_p0 == r_an_p1) && (r_segs_p0 == r_segs_p1);
      w_dec  = seg_decode(r_segs_p0);
      w_idx  = '0;
      for (int i = 0; i < NDIGITS; i++) begin
         if (!r_an_p0[i]) w_idx = IDXW'(i);
      end
   end

   // Run tracking and commit decision.
   always_comb begin
      w_state_nxt = r_state;
      w_run_nxt   = r_run;
      w_commit    = 1'b0;
      if (!w_lit) begin
         w_state_nxt = S_IDLE;
         w_run_nxt   = '0;
      end else if (!(r_state == S_HELD && w_same)) begin
         // A held digit that stays put is never recommitted; anything else
         // either extends the current run or starts a fresh one.
         if (r_state == S_TRACK && w_same)
            w_run_nxt = (r_run == RUN_MAX) ? r_run : r_run + RUN_ONE;
         else
            w_run_nxt = RUN_ONE;
         if (w_run_nxt == RUN_MAX) begin
            w_commit    = 1'b1;
            w_state_nxt = S_HELD;
         end else begin
            w_state_nxt = S_TRACK;
         end
      end
   end

   always_comb begin
      w_commit_bit        = '0;
      w_commit_bit[w_idx] = w_commit;
      w_mask_nxt          = r_mask | w_commit_bit;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_an_p0   <= '1;
         r_an_p1   <= '1;
         r_segs_p0 <= '1;
         r_segs_p1 <= '1;
         r_state   <= S_IDLE;
         r_run     <= '0;
         r_mask    <= '0;
         r_digits  <= '0;
         r_valid   <= '0;
         r_frame   <= 1'b0;
         r_err     <= 1'b0;
         r_err_idx <= '0;
      end else begin
         // input sample -> previous sample
         r_an_p0   <= io_bus.an_n;
         r_segs_p0 <= io_bus.segs_n;
         r_an_p1   <= r_an_p0;
         r_segs_p1 <= r_segs_p0;
         // FSM and commit outputs
         r_state   <= w_state_nxt;
         r_run     <= w_run_nxt;
         r_err     <= 1'b0;
         r_frame   <= 1'b0;
         if (w_commit) begin
            if (w_dec[4]) begin
               r_digits[4*w_idx +: 4] <= w_dec[3:0];
               r_valid[w_idx]         <= 1'b1;
            end else begin
               // Illegal pattern keeps the old value but marks it stale.
               r_valid[w_idx] <= 1'b0;
               r_err          <= 1'b1;
               r_err_idx      <= w_idx;
            end
         end
         if (w_mask_nxt == MASK_FULL) begin
            r_frame <= 1'b1;
            r_mask  <= '0;
         end else begin
            r_mask  <= w_mask_nxt;
         end
      end
   end

   assign io_bus.digits      = r_digits;
   assign io_bus.digit_valid = r_valid;
   assign io_bus.frame_done  = r_frame;
   assign io_bus.err         = r_err;
   assign io_bus.err_idx     = r_err_idx;
endmodule

// File: tb/tb_seg_scan_reader.sv
`timescale 1ns/1ps
module tb_seg_scan_reader;
   localparam int NDIGITS    = 8;
   localparam int STABLE_CNT = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   seg_scan_reader_if #(.NDIGITS(NDIGITS)) bus ();

   seg_scan_reader #(.NDIGITS(NDIGITS), .STABLE_CNT(STABLE_CNT)) dut (
      .clk    (clk),
      .rst    (rst),
      .io_bus (bus)
   );

   typedef struct {
      int       cyc;
      int       idx;
      logic [3:0] val;
      bit       legal;
      bit       frame;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          n_frames = 0;
   int          n_errs = 0;
   bit          mon_en = 1'b0;
   logic [7:0]  tb_mask = '0;
   logic [31:0] cur_digits = '0;
   logic [7:0]  cur_valid = '0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [6:0] seg_of(input int v);
      case (v)
         0: return 7'b1000000;
         1: return 7'b1111001;
         2: return 7'b0100100;
         3: return 7'b0110000;
         4: return 7'b0011001;
         5: return 7'b0010010;
         6: return 7'b0000010;
         7: return 7'b1111000;
         8: return 7'b0000000;
         default: return 7'b0010000;
      endcase
   endfunction

   // Pattern applied now and held: it is visible STABLE_CNT+1 edges later.
   task automatic expect_commit(input int idx, input int val, input bit legal);
      exp_t e;
      e.cyc   = cyc + STABLE_CNT + 1;
      e.idx   = idx;
      e.val   = val[3:0];
      e.legal = legal;
      tb_mask[idx] = 1'b1;
      e.frame = (tb_mask == 8'hFF);
      if (e.frame) tb_mask = '0;
      sb.push_back(e);
   endtask

   task automatic drive(input logic [7:0] an, input logic [6:0] s, input int n);
      bus.an_n   = an;
      bus.segs_n = s;
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_reset();
      #1 rst = 1'b1;
      @(negedge clk);
      #1 rst = 1'b0;
      tb_mask = '0;
   endtask

   task automatic test_reset();
      bus.an_n = '1; bus.segs_n = '1;
      repeat (3) @(negedge clk);
      checks += 5;
      if (bus.digits !== '0) begin errors++; $display("FAIL reset_digits got %h want 0", bus.digits); end
      if (bus.digit_valid !== '0) begin errors++; $display("FAIL reset_valid got %h want 0", bus.digit_valid); end
      if (bus.frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame got %b want 0", bus.frame_done); end
      if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", bus.err); end
      if (bus.err_idx !== '0) begin errors++; $display("FAIL reset_err_idx got %0d want 0", bus.err_idx); end
      #1 rst = 1'b0;
      mon_en = 1'b1;
   endtask

   task automatic test_single_digit();
      expect_commit(0, 2, 1'b1);
      drive(8'hFE, seg_of(2), 4);
      checks += 4;
      if (bus.digits[3:0] !== 4'd2) begin errors++; $display("FAIL single_value got %h want 2", bus.digits[3:0]); end
      if (bus.digit_valid[0] !== 1'b1) begin errors++; $display("FAIL single_valid got %b want 1", bus.digit_valid[0]); end
      if (bus.err !== 1'b0) begin errors++; $display("FAIL single_err got %b want 0", bus.err); end
      if (bus.frame_done !== 1'b0) begin errors++; $display("FAIL single_frame got %b want 0", bus.frame_done); end
      drive(8'hFF, 7'h7F, 3);
   endtask

   task automatic test_scan();
      int f0;
      pulse_reset();
      f0 = n_frames;
      for (int d = 0; d < 8; d++) begin
         expect_commit(d, d, 1'b1);
         drive(~(8'h01 << d), seg_of(d), 5);
      end
      drive(8'hFF, 7'h7F, 2);
      checks += 3;
      if (bus.digits !== 32'h76543210) begin errors++; $display("FAIL scan_digits got %h want 76543210", bus.digits); end
      if (bus.digit_valid !== 8'hFF) begin errors++; $display("FAIL scan_valid got %h want ff", bus.digit_valid); end
      if (n_frames - f0 != 1) begin errors++; $display("FAIL scan_frames got %0d want 1", n_frames - f0); end
   endtask

   task automatic test_glitch();
      drive(8'hF7, 7'b0000000, 2);
      expect_commit(3, 1, 1'b1);
      drive(8'hF7, seg_of(1), 3);
      drive(8'hFF, 7'h7F, 2);
      checks += 1;
      if (bus.digits[15:12] !== 4'd1) begin errors++; $display("FAIL glitch_value got %h want 1", bus.digits[15:12]); end
   endtask

   task automatic test_dash();
      int e0;
      e0 = n_errs;
`ifdef SEG_READER_DASH_EN
      expect_commit(5, 15, 1'b1);
`else
      expect_commit(5, 0, 1'b0);
`endif
      drive(8'hDF, 7'b0111111, 5);
      drive(8'hFF, 7'h7F, 2);
      checks += 3;
`ifdef SEG_READER_DASH_EN
      if (bus.digits[23:20] !== 4'hF) begin errors++; $display("FAIL dash_value got %h want f", bus.digits[23:20]); end
      if (bus.digit_valid[5] !== 1'b1) begin errors++; $display("FAIL dash_valid got %b want 1", bus.digit_valid[5]); end
      if (n_errs - e0 != 0) begin errors++; $display("FAIL dash_errs got %0d want 0", n_errs - e0); end
`else
      if (bus.digits[23:20] !== 4'h5) begin errors++; $display("FAIL dash_value got %h want 5", bus.digits[23:20]); end
      if (bus.digit_valid[5] !== 1'b0) begin errors++; $display("FAIL dash_valid got %b want 0", bus.digit_valid[5]); end
      if (n_errs - e0 != 1) begin errors++; $display("FAIL dash_errs got %0d want 1", n_errs - e0); end
`endif
   endtask

   task automatic test_two_low();
      int e0, f0;
      e0 = n_errs; f0 = n_frames;
      drive(8'hF3, seg_of(9), 10);
      drive(8'hFF, 7'h7F, 2);
      checks += 3;
      if (bus.digits !== cur_digits) begin errors++; $display("FAIL twolow_digits got %h want %h", bus.digits, cur_digits); end
      if (bus.digit_valid !== cur_valid) begin errors++; $display("FAIL twolow_valid got %h want %h", bus.digit_valid, cur_valid); end
      if (n_errs != e0 || n_frames != f0) begin errors++; $display("FAIL twolow_pulses got %0d/%0d want 0/0", n_errs - e0, n_frames - f0); end
   endtask

   task automatic test_async_reset();
      drive(8'hFD, seg_of(4), 3);
      #1 rst = 1'b1;
      #1;
      checks += 3;
      if (bus.digits !== '0) begin errors++; $display("FAIL async_digits got %h want 0", bus.digits); end
      if (bus.digit_valid !== '0) begin errors++; $display("FAIL async_valid got %h want 0", bus.digit_valid); end
      if (bus.err !== 1'b0 || bus.frame_done !== 1'b0) begin errors++; $display("FAIL async_pulses got %b%b want 00", bus.err, bus.frame_done); end
      @(negedge clk);
      #1 rst = 1'b0;
      tb_mask = '0;
      expect_commit(1, 4, 1'b1);
      repeat (3) @(negedge clk);
      checks += 1;
      if (bus.digits[7:4] !== 4'd0) begin errors++; $display("FAIL async_early got %h want 0", bus.digits[7:4]); end
      @(negedge clk);
      checks += 2;
      if (bus.digits !== 32'h00000040) begin errors++; $display("FAIL async_commit got %h want 00000040", bus.digits); end
      if (bus.digit_valid !== 8'h02) begin errors++; $display("FAIL async_valid2 got %h want 02", bus.digit_valid); end
      drive(8'hFF, 7'h7F, 2);
   endtask

   initial begin
      bus.an_n   = '1;
      bus.segs_n = '1;
      fork
         forever begin
            @(negedge clk);
            if (rst) begin
               cur_digits = '0;
               cur_valid  = '0;
            end else if (mon_en) begin
               exp_t e;
               bit   e_err, e_frame;
               int   e_idx;
               e_err = 1'b0; e_frame = 1'b0; e_idx = 0;
               if (bus.frame_done === 1'b1) n_frames++;
               if (bus.err === 1'b1) n_errs++;
               if (sb.size() > 0 && sb[0].cyc < cyc) begin
                  checks++; errors++;
                  $display("FAIL sb_missed got cycle %0d want cycle %0d", cyc, sb[0].cyc);
                  void'(sb.pop_front());
               end
               if (sb.size() > 0 && sb[0].cyc == cyc) begin
                  e = sb.pop_front();
                  if (e.legal) begin
                     cur_digits[4*e.idx +: 4] = e.val;
                     cur_valid[e.idx] = 1'b1;
                  end else begin
                     cur_valid[e.idx] = 1'b0;
                     e_err = 1'b1;
                     e_idx = e.idx;
                  end
                  e_frame = e.frame;
               end
               checks += 4;
               if (bus.digits !== cur_digits) begin errors++; $display("FAIL sb_digits cyc %0d got %h want %h", cyc, bus.digits, cur_digits); end
               if (bus.digit_valid !== cur_valid) begin errors++; $display("FAIL sb_valid cyc %0d got %h want %h", cyc, bus.digit_valid, cur_valid); end
               if (bus.err !== e_err) begin errors++; $display("FAIL sb_err cyc %0d got %b want %b", cyc, bus.err, e_err); end
               if (bus.frame_done !== e_frame) begin errors++; $display("FAIL sb_frame cyc %0d got %b want %b", cyc, bus.frame_done, e_frame); end
               if (e_err) begin
                  checks++;
                  if (int'(bus.err_idx) != e_idx) begin errors++; $display("FAIL sb_err_idx cyc %0d got %0d want %0d", cyc, bus.err_idx, e_idx); end
               end
            end
         end
      join_none

      test_reset();
      test_single_digit();
      test_scan();
      test_glitch();
      test_dash();
      test_two_low();
      test_async_reset();

      for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL sb_drain got %0d pending want 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
